// File: rtl/wb_trace_buffer.sv
// Write-back trace recorder: circular buffer of WB events drained through a FWFT valid/ready port.
// Optional per-entry cycle stamp enabled by defining WB_TRACE_STAMP_EN.
module wb_trace_buffer #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3,
  parameter int PC_W   = 16,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     arm_i,
  input  logic                     stop_i,
  input  logic                     wrap_i,
  input  logic                     wb_en_i,
  input  logic [REG_AW-1:0]        dest_reg_addr_i,
  input  logic [DATA_W-1:0]        wb_data_i,
  input  logic [PC_W-1:0]          pc_i,
  input  logic                     rd_ready_i,
  output logic                     rd_valid_o,
  output logic [REG_AW-1:0]        rd_addr_o,
  output logic [DATA_W-1:0]        rd_data_o,
  output logic [PC_W-1:0]          rd_pc_o,
  output logic [CNT_W-1:0]         rd_stamp_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     overflow_o,
  output logic [1:0]               state_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);
`ifdef WB_TRACE_STAMP_EN
  localparam int ENTRY_W = REG_AW + DATA_W + PC_W + CNT_W;
`else
  localparam int ENTRY_W = REG_AW + DATA_W + PC_W;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, CAPTURE = 2'd1, HALT = 2'd2} state_t;

  state_t             state_reg, state_next;
  logic [PTR_W-1:0]   wptr_reg, wptr_next;
  logic [PTR_W-1:0]   rptr_reg, rptr_next;
  logic [PTR_W:0]     count_reg, count_next;
  logic               overflow_reg, overflow_next;
  logic               wrap_reg, wrap_next;
  logic               wr_en, pop, full;
  logic [ENTRY_W-1:0] wr_entry, head_entry;
  logic [ENTRY_W-1:0] mem [DEPTH];

  assign full = (count_reg == FULL_CNT);
  assign pop  = (count_reg != '0) && rd_ready_i;

  always_comb begin
    state_next    = state_reg;
    wptr_next     = wptr_reg;
    rptr_next     = rptr_reg;
    count_next    = count_reg;
    overflow_next = overflow_reg;
    wrap_next     = wrap_reg;
    wr_en         = 1'b0;
    if (arm_i) begin
      state_next    = CAPTURE;
      wptr_next     = '0;
      rptr_next     = '0;
      count_next    = '0;
      overflow_next = 1'b0;
      wrap_next     = wrap_i;
    end else begin
      if (pop) begin
        rptr_next  = rptr_reg + 1'b1;
        count_next = count_reg - 1'b1;
      end
      if (state_reg == CAPTURE) begin
        if (wb_en_i) begin
          if (!full || pop) begin
            // a same-cycle pop frees a slot, so a push never overwrites here
            wr_en      = 1'b1;
            wptr_next  = wptr_reg + 1'b1;
            count_next = pop ? count_reg : count_reg + 1'b1;
            if (!wrap_reg && count_next == FULL_CNT) state_next = HALT;
          end else if (wrap_reg) begin
            wr_en         = 1'b1;
            wptr_next     = wptr_reg + 1'b1;
            rptr_next     = rptr_reg + 1'b1;
            overflow_next = 1'b1;
          end else begin
            overflow_next = 1'b1;
            state_next    = HALT;
          end
        end
        if (stop_i) state_next = HALT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      wptr_reg     <= '0;
      rptr_reg     <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      wrap_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wptr_reg     <= wptr_next;
      rptr_reg     <= rptr_next;
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
      wrap_reg     <= wrap_next;
    end
  end

`ifdef WB_TRACE_STAMP_EN
  logic [CNT_W-1:0] cycle_reg;

  // saturating stamp counter; frozen outside CAPTURE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                        cycle_reg <= '0;
    else if (arm_i)                                  cycle_reg <= '0;
    else if (state_reg == CAPTURE && cycle_reg != '1) cycle_reg <= cycle_reg + 1'b1;
  end

  assign wr_entry   = {dest_reg_addr_i, wb_data_i, pc_i, cycle_reg};
  assign rd_stamp_o = head_entry[CNT_W-1:0];
`else
  assign wr_entry   = {dest_reg_addr_i, wb_data_i, pc_i};
  assign rd_stamp_o = '0;
`endif

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr_reg] <= wr_entry;
  end

  assign head_entry = mem[rptr_reg];
  assign rd_addr_o  = head_entry[ENTRY_W-1 -: REG_AW];
  assign rd_data_o  = head_entry[ENTRY_W-REG_AW-1 -: DATA_W];
  assign rd_pc_o    = head_entry[ENTRY_W-REG_AW-DATA_W-1 -: PC_W];
  assign rd_valid_o = (count_reg != '0);
  assign count_o    = count_reg;
  assign full_o     = full;
  assign overflow_o = overflow_reg;
  assign state_o    = state_reg;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Bench for wb_trace_buffer (DEPTH=4): directed scenarios with literal checks, then random
// traffic compared every cycle against a queue-based model.
module tb_wb_trace_buffer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, arm, stop, wrap, wb_en, rd_ready;
  logic [2:0]  dest;
  logic [15:0] wdata, pc;
  logic        rd_valid, full, overflow;
  logic [2:0]  rd_addr;
  logic [15:0] rd_data, rd_pc;
  logic [31:0] rd_stamp;
  logic [2:0]  count;
  logic [1:0]  state;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  wb_trace_buffer #(.DATA_W(16), .REG_AW(3), .PC_W(16), .DEPTH(DEPTH), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .arm_i(arm), .stop_i(stop), .wrap_i(wrap), .wb_en_i(wb_en),
    .dest_reg_addr_i(dest), .wb_data_i(wdata), .pc_i(pc), .rd_ready_i(rd_ready),
    .rd_valid_o(rd_valid), .rd_addr_o(rd_addr), .rd_data_o(rd_data), .rd_pc_o(rd_pc),
    .rd_stamp_o(rd_stamp), .count_o(count), .full_o(full), .overflow_o(overflow),
    .state_o(state)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [2:0]  addr;
    logic [15:0] data;
    logic [15:0] pc;
    logic [31:0] stamp;
  } ent_t;

  ent_t        q[$];
  ent_t        e;
  int          m_state;
  bit          m_ovf, m_wrap, m_pop;
  logic [31:0] m_cyc;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete(); m_state = 0; m_ovf = 0; m_wrap = 0; m_cyc = 0;
    end else if (arm) begin
      q.delete(); m_state = 1; m_ovf = 0; m_wrap = wrap; m_cyc = 0;
    end else begin
      m_pop = (q.size() != 0) && rd_ready;
      if (m_state == 1) begin
        e.addr = dest; e.data = wdata; e.pc = pc;
`ifdef WB_TRACE_STAMP_EN
        e.stamp = m_cyc;
`else
        e.stamp = 0;
`endif
        if (wb_en) begin
          if (m_pop) begin
            void'(q.pop_front()); q.push_back(e);
          end else if (q.size() < DEPTH) begin
            q.push_back(e);
          end else if (m_wrap) begin
            void'(q.pop_front()); q.push_back(e); m_ovf = 1;
          end else begin
            m_ovf = 1; m_state = 2;
          end
          if (!m_wrap && q.size() == DEPTH) m_state = 2;
        end else if (m_pop) begin
          void'(q.pop_front());
        end
        if (stop) m_state = 2;
        if (m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 1;
      end else if (m_pop) begin
        void'(q.pop_front());
      end
    end
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (rst) begin
      chk("state", state, m_state);
      chk("count", count, q.size());
      chk("full", full, q.size() == DEPTH);
      chk("overflow", overflow, m_ovf);
      chk("rd_valid", rd_valid, q.size() != 0);
      if (q.size() != 0) begin
        chk("rd_addr", rd_addr, q[0].addr);
        chk("rd_data", rd_data, q[0].data);
        chk("rd_pc", rd_pc, q[0].pc);
        chk("rd_stamp", rd_stamp, q[0].stamp);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_arm(input logic w);
    arm = 1; wrap = w; tick(); arm = 0;
  endtask

  task automatic push(input logic [2:0] a, input logic [15:0] d, input logic [15:0] p);
    wb_en = 1; dest = a; wdata = d; pc = p; tick(); wb_en = 0;
  endtask

  initial begin
    logic [31:0] s1, s2;
    int rdy_pct;
`ifdef WB_TRACE_STAMP_EN
    s1 = 3; s2 = 6;
`else
    s1 = 0; s2 = 0;
`endif
    rst = 0; arm = 0; stop = 0; wrap = 0; wb_en = 0; rd_ready = 0;
    dest = 0; wdata = 0; pc = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", state, 0);
    chk("reset_count", count, 0);
    chk("reset_valid", rd_valid, 0);
    chk("reset_ovf", overflow, 0);
    rst = 1; tick();

    // stop mode fill
    do_arm(0);
    for (int i = 1; i <= 4; i++) push(3'(i), 16'(16'h1111 * i), 16'(16'h100 + i));
    chk("stop_full", full, 1);
    chk("stop_state", state, 2);
    push(3'd5, 16'h5555, 16'h105);
    chk("stop_5th_count", count, 4);
    rd_ready = 1;
    for (int i = 1; i <= 4; i++) begin
      chk("stop_drain_addr", rd_addr, i);
      tick();
    end
    rd_ready = 0;
    chk("stop_drained", count, 0);

    // wrap mode overwrite
    do_arm(1);
    for (int i = 0; i < 6; i++) push(3'(i), 16'(i), 16'(16'h200 + i));
    chk("wrap_ovf", overflow, 1);
    chk("wrap_count", count, 4);
    rd_ready = 1;
    for (int i = 2; i <= 5; i++) begin
      chk("wrap_drain_data", rd_data, i);
      tick();
    end
    rd_ready = 0;

    // full in wrap mode, simultaneous push and pop
    do_arm(1);
    for (int i = 0; i < 4; i++) push(3'(i), 16'(16'hA + i), 16'(16'h300 + i));
    chk("pp_head_before", rd_data, 16'hA);
    rd_ready = 1;
    push(3'd7, 16'h9, 16'h399);
    rd_ready = 0;
    chk("pp_count", count, 4);
    chk("pp_ovf", overflow, 0);
    rd_ready = 1;
    chk("pp_drain0", rd_data, 16'hB); tick();
    chk("pp_drain1", rd_data, 16'hC); tick();
    chk("pp_drain2", rd_data, 16'hD); tick();
    chk("pp_tail", rd_data, 16'h9); tick();
    rd_ready = 0;

    // cycle stamps
    do_arm(0);
    repeat (3) tick();
    push(3'd1, 16'h0101, 16'h400);
    repeat (2) tick();
    push(3'd2, 16'h0202, 16'h401);
    chk("stamp_first", rd_stamp, s1);
    rd_ready = 1; tick(); rd_ready = 0;
    chk("stamp_second", rd_stamp, s2);

    // arm with an event while halted
    push(3'd3, 16'h0303, 16'h402);
    stop = 1; tick(); stop = 0;
    chk("halt_state", state, 2);
    chk("halt_count", count, 2);
    arm = 1; wb_en = 1; wrap = 0; dest = 3'd6; wdata = 16'h6666; tick();
    arm = 0; wb_en = 0;
    chk("rearm_count", count, 0);
    chk("rearm_state", state, 1);
    chk("rearm_valid", rd_valid, 0);

    // asynchronous reset mid-capture with 3 entries held
    do_arm(1);
    for (int i = 0; i < 6; i++) push(3'(i), 16'(16'h700 + i), 16'(i));
    rd_ready = 1; tick(); rd_ready = 0;
    chk("pre_reset_count", count, 3);
    chk("pre_reset_ovf", overflow, 1);
    #2 rst = 0;
    #1;
    chk("areset_state", state, 0);
    chk("areset_count", count, 0);
    chk("areset_valid", rd_valid, 0);
    chk("areset_ovf", overflow, 0);
    tick();
    rst = 1;

    // randomized traffic
    rdy_pct = 50;
    for (int n = 0; n < 3000; n++) begin
      if (n % 200 == 0) rdy_pct = $urandom_range(10, 90);
      arm      = ($urandom % 50) == 0;
      wrap     = $urandom % 2;
      stop     = ($urandom % 40) == 0;
      wb_en    = $urandom % 2;
      dest     = 3'($urandom);
      wdata    = 16'($urandom);
      pc       = 16'($urandom);
      rd_ready = $urandom_range(0, 99) < rdy_pct;
      tick();
    end
    arm = 0; stop = 0; wb_en = 0; rd_ready = 0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
